bitscan32_seq: RTL and testbench

BITSCAN32_SEQ -- requirements
Module: bitscan32_seq

---
 rtl/bitscan32_seq.sv | 104 ++++++++++
 tb/tb_bitscan32_seq.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bitscan32_seq.sv
// Decomposes a 32-bit word into one index beat per set bit (LSB- or MSB-first via SCAN_DIR).
// Optional macro BITSCAN_SKIPZERO_EN drops all-zero words instead of emitting an EMPTY beat.
module bitscan32_seq #(
  parameter int SCAN_DIR = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_index,
  output logic        out_last,
  output logic        out_zero,
  output logic [5:0]  out_seq,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SCAN, EMPTY} state_t;

  state_t      state_q, state_d;
  logic [31:0] pend_q, pend_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [4:0]  lo_idx, hi_idx, sel_idx;
  logic        one_hot;

  // Both priority encoders in one pass; last assignment wins for each direction.
  always_comb begin
    lo_idx = '0;
    hi_idx = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (pend_q[i])      hi_idx = 5'(i);
      if (pend_q[31 - i]) lo_idx = 5'(31 - i);
    end
  end

  assign sel_idx = (SCAN_DIR == 0) ? lo_idx : hi_idx;
  assign one_hot = (pend_q != '0) && ((pend_q & (pend_q - 32'd1)) == '0);
  assign busy    = (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_index = '0;
    out_last  = 1'b0;
    out_zero  = 1'b0;
    out_seq   = '0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          pend_d = in_word;
          cnt_d  = '0;
          if (in_word != '0) begin
            state_d = SCAN;
          end else begin
`ifdef BITSCAN_SKIPZERO_EN
            state_d = IDLE;
`else
            state_d = EMPTY;
`endif
          end
        end
      end
      SCAN: begin
        out_valid = 1'b1;
        out_index = sel_idx;
        out_last  = one_hot;
        out_seq   = cnt_q;
        if (out_ready) begin
          pend_d = pend_q & ~(32'd1 << sel_idx);
          cnt_d  = cnt_q + 6'd1;
          if (one_hot) state_d = IDLE;
        end
      end
      EMPTY: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
`ifndef BITSCAN_SKIPZERO_EN
        out_zero  = 1'b1;
`endif
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_bitscan32_seq.sv
// Directed bench for bitscan32_seq: one LSB-first and one MSB-first instance share all inputs.
module tb_bitscan32_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_word;
  logic        out_ready;

  logic        in_ready0, out_valid0, out_last0, out_zero0, busy0;
  logic [4:0]  out_index0;
  logic [5:0]  out_seq0;
  logic        in_ready1, out_valid1, out_last1, out_zero1, busy1;
  logic [4:0]  out_index1;
  logic [5:0]  out_seq1;

  int errors;
  int checks;

  bitscan32_seq #(.SCAN_DIR(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_word(in_word), .out_valid(out_valid0), .out_ready(out_ready),
    .out_index(out_index0), .out_last(out_last0), .out_zero(out_zero0),
    .out_seq(out_seq0), .busy(busy0)
  );

  bitscan32_seq #(.SCAN_DIR(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_word(in_word), .out_valid(out_valid1), .out_ready(out_ready),
    .out_index(out_index1), .out_last(out_last1), .out_zero(out_zero1),
    .out_seq(out_seq1), .busy(busy1)
  );

  // {valid, busy, in_ready, index, last, zero, seq}
  logic [15:0] obs0, obs1;
  assign obs0 = {out_valid0, busy0, in_ready0, out_index0, out_last0, out_zero0, out_seq0};
  assign obs1 = {out_valid1, busy1, in_ready1, out_index1, out_last1, out_zero1, out_seq1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ev(input logic v, input logic b, input logic r,
                                     input int idx, input logic l, input logic z, input int s);
    ev = {v, b, r, 5'(idx), l, z, 6'(s)};
  endfunction

  localparam logic [15:0] IDLE_OBS = 16'b0_0_1_00000_0_0_000000;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] w, input bit hold_valid);
    @(negedge clk);
    checks++;
    if (in_ready0 !== 1'b1) begin
      errors++;
      $display("FAIL offer_ready got=%b exp=1", in_ready0);
    end
    in_valid = 1'b1;
    in_word  = w;
    @(posedge clk);
    #1;
    if (!hold_valid) in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (obs0 !== IDLE_OBS) begin
      errors++; $display("FAIL reset_during got=%h exp=%h", obs0, IDLE_OBS);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step();
    checks++;
    if (obs1 !== IDLE_OBS) begin
      errors++; $display("FAIL reset_after got=%h exp=%h", obs1, IDLE_OBS);
    end
  endtask

  task automatic test_single();
    offer(32'h0100_0000, 1'b0);
    checks++;
    if (obs0 !== ev(1, 1, 0, 24, 1, 0, 0)) begin
      errors++; $display("FAIL single_beat got=%h exp=%h", obs0, ev(1, 1, 0, 24, 1, 0, 0));
    end
    step();
    checks++;
    if (obs0 !== IDLE_OBS) begin
      errors++; $display("FAIL single_idle got=%h exp=%h", obs0, IDLE_OBS);
    end
  endtask

  task automatic test_multi();
    int lo [6] = '{3, 10, 14, 18, 22, 24};
    int hi [6] = '{24, 22, 18, 14, 10, 3};
    offer(32'h0144_4408, 1'b0);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (obs0 !== ev(1, 1, 0, lo[i], i == 5, 0, i)) begin
        errors++; $display("FAIL multi_lsb[%0d] got=%h exp=%h", i, obs0, ev(1, 1, 0, lo[i], i == 5, 0, i));
      end
      checks++;
      if (obs1 !== ev(1, 1, 0, hi[i], i == 5, 0, i)) begin
        errors++; $display("FAIL multi_msb[%0d] got=%h exp=%h", i, obs1, ev(1, 1, 0, hi[i], i == 5, 0, i));
      end
      step();
    end
    checks++;
    if (obs0 !== IDLE_OBS) begin
      errors++; $display("FAIL multi_idle got=%h exp=%h", obs0, IDLE_OBS);
    end
  endtask

  task automatic test_zero();
    offer(32'h0000_0000, 1'b0);
`ifdef BITSCAN_SKIPZERO_EN
    checks++;
    if (obs0 !== IDLE_OBS) begin
      errors++; $display("FAIL zero_skip got=%h exp=%h", obs0, IDLE_OBS);
    end
    step();
    checks++;
    if (obs1 !== IDLE_OBS) begin
      errors++; $display("FAIL zero_skip_next got=%h exp=%h", obs1, IDLE_OBS);
    end
`else
    checks++;
    if (obs0 !== ev(1, 1, 0, 0, 1, 1, 0)) begin
      errors++; $display("FAIL zero_beat got=%h exp=%h", obs0, ev(1, 1, 0, 0, 1, 1, 0));
    end
    step();
    checks++;
    if (obs1 !== IDLE_OBS) begin
      errors++; $display("FAIL zero_idle got=%h exp=%h", obs1, IDLE_OBS);
    end
`endif
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    offer(32'h8000_0001, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs0 !== ev(1, 1, 0, 0, 0, 0, 0)) begin
        errors++; $display("FAIL stall_lsb[%0d] got=%h exp=%h", i, obs0, ev(1, 1, 0, 0, 0, 0, 0));
      end
      checks++;
      if (obs1 !== ev(1, 1, 0, 31, 0, 0, 0)) begin
        errors++; $display("FAIL stall_msb[%0d] got=%h exp=%h", i, obs1, ev(1, 1, 0, 31, 0, 0, 0));
      end
      step();
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (obs0 !== ev(1, 1, 0, 31, 1, 0, 1)) begin
      errors++; $display("FAIL stall_second_lsb got=%h exp=%h", obs0, ev(1, 1, 0, 31, 1, 0, 1));
    end
    checks++;
    if (obs1 !== ev(1, 1, 0, 0, 1, 0, 1)) begin
      errors++; $display("FAIL stall_second_msb got=%h exp=%h", obs1, ev(1, 1, 0, 0, 1, 0, 1));
    end
    step();
  endtask

  task automatic test_back_to_back();
    // in_valid stays high through the first word; the second word must wait for the IDLE bubble
    offer(32'h0000_0003, 1'b1);
    in_word = 32'h0000_0004;
    checks++;
    if (obs0 !== ev(1, 1, 0, 0, 0, 0, 0)) begin
      errors++; $display("FAIL b2b_a0 got=%h exp=%h", obs0, ev(1, 1, 0, 0, 0, 0, 0));
    end
    step();
    checks++;
    if (obs0 !== ev(1, 1, 0, 1, 1, 0, 1)) begin
      errors++; $display("FAIL b2b_a1 got=%h exp=%h", obs0, ev(1, 1, 0, 1, 1, 0, 1));
    end
    step();
    checks++;
    if (obs0 !== IDLE_OBS) begin
      errors++; $display("FAIL b2b_bubble got=%h exp=%h", obs0, IDLE_OBS);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (obs1 !== ev(1, 1, 0, 2, 1, 0, 0)) begin
      errors++; $display("FAIL b2b_b got=%h exp=%h", obs1, ev(1, 1, 0, 2, 1, 0, 0));
    end
    step();
  endtask

  task automatic test_reset_mid();
    offer(32'hFFFF_FFFF, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (obs0 !== ev(1, 1, 0, i, 0, 0, i)) begin
        errors++; $display("FAIL full_lsb[%0d] got=%h exp=%h", i, obs0, ev(1, 1, 0, i, 0, 0, i));
      end
      checks++;
      if (obs1 !== ev(1, 1, 0, 31 - i, 0, 0, i)) begin
        errors++; $display("FAIL full_msb[%0d] got=%h exp=%h", i, obs1, ev(1, 1, 0, 31 - i, 0, 0, i));
      end
      step();
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs0 !== IDLE_OBS) begin
      errors++; $display("FAIL midreset_lsb got=%h exp=%h", obs0, IDLE_OBS);
    end
    checks++;
    if (obs1 !== IDLE_OBS) begin
      errors++; $display("FAIL midreset_msb got=%h exp=%h", obs1, IDLE_OBS);
    end
    @(negedge clk) rst_n = 1'b1;
    offer(32'h0000_0010, 1'b0);
    checks++;
    if (obs0 !== ev(1, 1, 0, 4, 1, 0, 0)) begin
      errors++; $display("FAIL post_reset_lsb got=%h exp=%h", obs0, ev(1, 1, 0, 4, 1, 0, 0));
    end
    checks++;
    if (obs1 !== ev(1, 1, 0, 4, 1, 0, 0)) begin
      errors++; $display("FAIL post_reset_msb got=%h exp=%h", obs1, ev(1, 1, 0, 4, 1, 0, 0));
    end
    step();
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_word   = '0;
    out_ready = 1'b1;
    test_reset();
    test_single();
    test_multi();
    test_zero();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
